down_counter: RTL and testbench

- Loadable, prescaled down-counting timer. It is the decrementing counterpart of the free-running up counter.
- It accepts a start value over a valid/ready load handshake and decrements once per prescaler period.
- When it reaches zero it emits a one-cycle expired pulse, then either stops or auto-reloads.
- It sits beside the up counter and drives timeouts and periodic events for the ALU control logic.

---
 rtl/down_counter_if.sv | 32 +++
 rtl/down_counter.sv | 116 +++++++++++
 tb/tb_down_counter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/down_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_if
// Brief    : Load handshake, control and status bundle for down_counter.
// Revision : 1.0
// ============================================================================
interface down_counter_if #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 32
);
    logic [PRESCALE_WIDTH-1:0] prescaler_val;
    logic                      load_valid;
    logic [WIDTH-1:0]          load_value;
    logic                      load_ready;
    logic                      auto_reload;
    logic                      pause;
    logic                      abort;
    logic [WIDTH-1:0]          counter;
    logic                      busy;
    logic                      expired;

    modport master (
        output prescaler_val, load_valid, load_value, auto_reload, pause, abort,
        input  load_ready, counter, busy, expired
    );

    modport slave (
        input  prescaler_val, load_valid, load_value, auto_reload, pause, abort,
        output load_ready, counter, busy, expired
    );
endinterface
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module   : down_counter
// Brief    : Loadable, prescaled down-counting timer with expiry pulse and
//            optional auto-reload.
// Revision : 1.0
// ============================================================================
module down_counter #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 32
) (
    input  wire            clock,
    input  wire            reset_n,
    down_counter_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [0:0]                r_state;
    logic [0:0]                w_state_nxt;
    logic [WIDTH-1:0]          r_counter;
    logic [WIDTH-1:0]          r_reload;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic                      r_expired;
    logic                      w_load_ready;
    logic                      w_busy;
    logic                      w_load_fire;
    logic                      w_presc_wrap;
    logic                      w_tick;
    logic                      w_last;

    assign w_load_fire  = bus.load_valid && w_load_ready;
    // >= rather than == so a live shrink of prescaler_val never wraps the prescaler
    assign w_presc_wrap = (r_presc >= bus.prescaler_val);
    assign w_tick       = (r_state == S_RUN) && !bus.abort && !bus.pause && w_presc_wrap;
    assign w_last       = (r_counter == c_ONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load_fire && (bus.load_value != c_ZERO)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick && w_last && !bus.auto_reload) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_ready = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE:  w_load_ready = reset_n && !bus.abort;
            S_RUN:   w_busy       = 1'b1;
            default: w_load_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_counter <= '0;
            r_reload  <= '0;
            r_presc   <= '0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_load_fire) begin
                    r_counter <= bus.load_value;
                    r_reload  <= bus.load_value;
                    r_presc   <= '0;
                    r_expired <= (bus.load_value == c_ZERO);
                end
            end else if (bus.abort) begin
                r_counter <= '0;
                r_presc   <= '0;
            end else if (!bus.pause) begin
                if (w_presc_wrap) begin
                    r_presc <= '0;
                    if (!w_last) begin
                        r_counter <= r_counter - c_ONE;
                    end else begin
                        r_counter <= bus.auto_reload ? r_reload : c_ZERO;
                        r_expired <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.busy       = w_busy;
    assign bus.counter    = r_counter;
    assign bus.expired    = r_expired;
endmodule
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_counter
// Brief    : Directed scoreboard bench for down_counter.
// Revision : 1.0
// ============================================================================
module tb_down_counter;
    typedef struct packed {
        logic [7:0] cnt;
        logic       busy;
        logic       expd;
        logic       rdy;
    } exp_t;

    logic  clock;
    logic  reset_n;
    int    checks;
    int    errors;
    exp_t  q_exp[$];
    string q_tag[$];

    down_counter_if #(.WIDTH(8), .PRESCALE_WIDTH(32)) bus ();

    down_counter #(.WIDTH(8), .PRESCALE_WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input string tag, input logic [7:0] c, input logic b,
                              input logic e, input logic r);
        exp_t ex;
        ex.cnt  = c;
        ex.busy = b;
        ex.expd = e;
        ex.rdy  = r;
        q_exp.push_back(ex);
        q_tag.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  ex;
        exp_t  obs;
        string t;
        ex  = q_exp.pop_front();
        t   = q_tag.pop_front();
        obs = {bus.counter, bus.busy, bus.expired, bus.load_ready};
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s: observed cnt=%0d busy=%b expired=%b ready=%b, expected cnt=%0d busy=%b expired=%b ready=%b",
                   t, obs.cnt, obs.busy, obs.expd, obs.rdy, ex.cnt, ex.busy, ex.expd, ex.rdy);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] c, input logic b,
                        input logic e, input logic r);
        expect_out(tag, c, b, e, r);
        @(posedge clock);
        #1;
        check_out();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n           = 1'b0;
        bus.prescaler_val = '0;
        bus.load_valid    = 1'b0;
        bus.load_value    = '0;
        bus.auto_reload   = 1'b0;
        bus.pause         = 1'b0;
        bus.abort         = 1'b0;
        #2;
        expect_out("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        @(posedge clock); #3;
        reset_n = 1'b1;
        #1;
        expect_out("ready_after_reset", 8'd0, 1'b0, 1'b0, 1'b1);
        check_out();
        @(posedge clock); #1;

        // 1: P=0, one-shot count from 5
        bus.load_valid = 1'b1;
        bus.load_value = 8'd5;
        step("t1_load", 8'd5, 1'b1, 1'b0, 1'b0);
        bus.load_valid = 1'b0;
        for (int i = 4; i >= 1; i--) step("t1_count", 8'(i), 1'b1, 1'b0, 1'b0);
        step("t1_expire", 8'd0, 1'b0, 1'b1, 1'b1);
        step("t1_after", 8'd0, 1'b0, 1'b0, 1'b1);

        // 2: P=3, load 2 -> 8 edges to expiry
        bus.prescaler_val = 32'd3;
        bus.load_valid    = 1'b1;
        bus.load_value    = 8'd2;
        step("t2_load", 8'd2, 1'b1, 1'b0, 1'b0);
        bus.load_valid = 1'b0;
        for (int i = 0; i < 3; i++) step("t2_hold2", 8'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("t2_hold1", 8'd1, 1'b1, 1'b0, 1'b0);
        step("t2_expire", 8'd0, 1'b0, 1'b1, 1'b1);

        // 3: auto-reload from 3, then drop auto_reload
        bus.prescaler_val = 32'd0;
        bus.auto_reload   = 1'b1;
        bus.load_valid    = 1'b1;
        bus.load_value    = 8'd3;
        step("t3_load", 8'd3, 1'b1, 1'b0, 1'b0);
        bus.load_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step("t3_cnt2", 8'd2, 1'b1, 1'b0, 1'b0);
            step("t3_cnt1", 8'd1, 1'b1, 1'b0, 1'b0);
            step("t3_reload", 8'd3, 1'b1, 1'b1, 1'b0);
        end
        bus.auto_reload = 1'b0;
        step("t3_cnt2b", 8'd2, 1'b1, 1'b0, 1'b0);
        step("t3_cnt1b", 8'd1, 1'b1, 1'b0, 1'b0);
        step("t3_stop", 8'd0, 1'b0, 1'b1, 1'b1);

        // 4: pause for 10 cycles after first tick
        bus.load_valid = 1'b1;
        bus.load_value = 8'd4;
        step("t4_load", 8'd4, 1'b1, 1'b0, 1'b0);
        bus.load_valid = 1'b0;
        step("t4_tick1", 8'd3, 1'b1, 1'b0, 1'b0);
        bus.pause = 1'b1;
        for (int i = 0; i < 10; i++) step("t4_paused", 8'd3, 1'b1, 1'b0, 1'b0);
        bus.pause = 1'b0;
        step("t4_cnt2", 8'd2, 1'b1, 1'b0, 1'b0);
        step("t4_cnt1", 8'd1, 1'b1, 1'b0, 1'b0);
        step("t4_expire", 8'd0, 1'b0, 1'b1, 1'b1);

        // 5: abort at counter=2, blocked load, then load 0
        bus.load_valid = 1'b1;
        bus.load_value = 8'd6;
        step("t5_load", 8'd6, 1'b1, 1'b0, 1'b0);
        bus.load_valid = 1'b0;
        for (int i = 5; i >= 2; i--) step("t5_count", 8'(i), 1'b1, 1'b0, 1'b0);
        bus.abort = 1'b1;
        step("t5_abort", 8'd0, 1'b0, 1'b0, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_value = 8'd9;
        step("t5_load_blocked", 8'd0, 1'b0, 1'b0, 1'b0);
        bus.abort      = 1'b0;
        bus.load_value = 8'd0;
        step("t5_load_zero", 8'd0, 1'b0, 1'b1, 1'b1);
        bus.load_valid = 1'b0;
        step("t5_after_zero", 8'd0, 1'b0, 1'b0, 1'b1);

        // 6: async reset mid-count
        bus.prescaler_val = 32'd7;
        bus.load_valid    = 1'b1;
        bus.load_value    = 8'd200;
        step("t6_load", 8'd200, 1'b1, 1'b0, 1'b0);
        bus.load_valid = 1'b0;
        for (int i = 0; i < 7; i++) step("t6_hold200", 8'd200, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t6_hold199", 8'd199, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("t6_async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        step("t6_in_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        #3;
        reset_n = 1'b1;
        #1;
        expect_out("t6_released", 8'd0, 1'b0, 1'b0, 1'b1);
        check_out();
        step("t6_idle", 8'd0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
